// File: rtl/market_pkt_repack.sv
// market_pkt_repack: strips the leading invalid bytes from the parser's
// market_pkt stream and repacks the payload into dense, left-aligned 64-bit
// words for the DMA stage. It also reports per-packet payload length and
// keeps counters of good and bad packets.
module market_pkt_repack #(
  parameter logic [15:0] MAX_LEN = 16'd9000,
  parameter int          CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [63:0]      in_data,
  input  logic             in_sop,
  input  logic [3:0]       in_offset,
  input  logic             in_eop,
  input  logic [2:0]       in_byte,
  output logic             in_ready,
  output logic             out_vld,
  output logic [63:0]      out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic [2:0]       out_byte,
  output logic [15:0]      out_len,
  output logic             out_err,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Packing state
  state_t      state_reg, state_next;
  logic [2:0]  r_reg, r_next;              // residual byte count, 0..7
  logic [55:0] res_reg, res_next;          // residual bytes, left-aligned, zero-filled
  logic [15:0] len_reg, len_next;          // payload bytes so far in this packet
  logic        sop_pend_reg, sop_pend_next;  // no word emitted yet for this packet
  logic        orphan_reg, orphan_next;    // inside a run of dropped non-sop beats

  // Output register
  logic        out_vld_reg;
  logic [63:0] out_data_reg;
  logic        out_sop_reg;
  logic        out_eop_reg;
  logic [2:0]  out_byte_reg;
  logic [15:0] out_len_reg;
  logic        out_err_reg;

  logic [CNT_W-1:0] pkt_cnt_reg;
  logic [CNT_W-1:0] err_cnt_reg;

  // Load request towards the output register
  logic        load;
  logic [63:0] ld_data;
  logic        ld_sop;
  logic        ld_eop;
  logic [2:0]  ld_byte;
  logic [15:0] ld_len;
  logic        ld_err;
  logic        pkt_inc;
  logic        err_inc;
  logic        take_beat;

  // Beat decode
  logic        out_free;
  logic [3:0]  beat_s;
  logic [3:0]  beat_e;
  logic [3:0]  beat_v;
  logic        zero_len;
  logic [63:0] shifted;
  logic [63:0] keep_mask;
  logic [63:0] masked;

  // Merge of the residual with the new bytes
  logic [2:0]   eff_r;
  logic [55:0]  eff_res;
  logic         eff_sop;
  logic [15:0]  eff_len;
  logic [119:0] placed;
  logic [119:0] merged;
  logic [3:0]   total;
  logic [3:0]   total_m8;
  logic [16:0]  sum_len;
  logic [15:0]  new_len;
  logic         new_len_big;

  assign out_free = ~out_vld_reg | out_ready;

  // Decode the valid byte window [s, e) of the presented beat and isolate
  // those bytes at the top of a word.
  always_comb begin
    beat_s    = in_sop ? ((in_offset > 4'd7) ? 4'd7 : in_offset) : 4'd0;
    beat_e    = in_eop ? ((in_byte == 3'd0) ? 4'd8 : {1'b0, in_byte}) : 4'd8;
    zero_len  = (beat_e <= beat_s);
    beat_v    = zero_len ? 4'd0 : (beat_e - beat_s);
    shifted   = in_data << {beat_s, 3'b000};
    keep_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> {beat_v, 3'b000});
    masked    = shifted & keep_mask;
  end

  // Append the new bytes behind the residual; a beat accepted in IDLE always
  // starts from an empty residual and a fresh length.
  always_comb begin
    if (state_reg == IDLE) begin
      eff_r   = 3'd0;
      eff_res = 56'd0;
      eff_sop = 1'b1;
      eff_len = 16'd0;
    end else begin
      eff_r   = r_reg;
      eff_res = res_reg;
      eff_sop = sop_pend_reg;
      eff_len = len_reg;
    end
    placed      = {masked, 56'd0} >> {eff_r, 3'b000};
    merged      = {eff_res, 64'd0} | placed;
    total       = {1'b0, eff_r} + beat_v;
    total_m8    = total - 4'd8;
    sum_len     = {1'b0, eff_len} + {13'd0, beat_v};
    new_len     = sum_len[16] ? 16'hFFFF : sum_len[15:0];
    new_len_big = (new_len > MAX_LEN);
  end

  // Next-state, residual update, output load and counter requests.
  always_comb begin
    state_next    = state_reg;
    r_next        = r_reg;
    res_next      = res_reg;
    len_next      = len_reg;
    sop_pend_next = sop_pend_reg;
    orphan_next   = orphan_reg;
    in_ready      = 1'b0;
    take_beat     = 1'b0;
    load          = 1'b0;
    ld_data       = 64'd0;
    ld_sop        = 1'b0;
    ld_eop        = 1'b0;
    ld_byte       = 3'd0;
    ld_len        = 16'd0;
    ld_err        = 1'b0;
    pkt_inc       = 1'b0;
    err_inc       = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready = out_free;
        if (in_vld && out_free) begin
          if (!in_sop) begin
            // Orphan beat: dropped, counted once per run.
            orphan_next = 1'b1;
            err_inc     = ~orphan_reg;
          end else begin
            orphan_next = 1'b0;
            if (in_eop && zero_len) begin
              err_inc = 1'b1;
            end else begin
              take_beat = 1'b1;
            end
          end
        end
      end
      PACK: begin
        // A sop arriving before the eop is left with upstream (ready masked)
        // and replayed from IDLE once the abort word has gone out.
        if (in_vld && in_sop) begin
          state_next = ABORT;
        end else begin
          in_ready = out_free;
          if (in_vld && out_free) begin
            take_beat = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          load          = 1'b1;
          ld_data       = {res_reg, 8'd0};
          ld_sop        = sop_pend_reg;
          ld_eop        = 1'b1;
          ld_byte       = r_reg;
          ld_len        = len_reg;
          ld_err        = (len_reg > MAX_LEN);
          pkt_inc       = ~(len_reg > MAX_LEN);
          err_inc       = (len_reg > MAX_LEN);
          state_next    = IDLE;
          r_next        = 3'd0;
          res_next      = 56'd0;
          len_next      = 16'd0;
          sop_pend_next = 1'b0;
        end
      end
      ABORT: begin
        if (out_free) begin
          load          = 1'b1;
          ld_data       = (r_reg == 3'd0) ? 64'd0 : {res_reg, 8'd0};
          ld_byte       = (r_reg == 3'd0) ? 3'd1 : r_reg;
          ld_sop        = sop_pend_reg;
          ld_eop        = 1'b1;
          ld_len        = len_reg;
          ld_err        = 1'b1;
          err_inc       = 1'b1;
          state_next    = IDLE;
          r_next        = 3'd0;
          res_next      = 56'd0;
          len_next      = 16'd0;
          sop_pend_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (take_beat) begin
      len_next = new_len;
      if (in_eop && (total <= 4'd8)) begin
        // Whole remainder of the packet fits in one final word.
        load          = 1'b1;
        ld_data       = merged[119:56];
        ld_sop        = eff_sop;
        ld_eop        = 1'b1;
        ld_byte       = total[2:0];
        ld_len        = new_len;
        ld_err        = new_len_big;
        pkt_inc       = ~new_len_big;
        err_inc       = new_len_big;
        state_next    = IDLE;
        r_next        = 3'd0;
        res_next      = 56'd0;
        len_next      = 16'd0;
        sop_pend_next = 1'b0;
      end else if (total >= 4'd8) begin
        // A full word is ready; the overflow stays as the new residual.
        load          = 1'b1;
        ld_data       = merged[119:56];
        ld_sop        = eff_sop;
        r_next        = total_m8[2:0];
        res_next      = merged[55:0];
        sop_pend_next = 1'b0;
        state_next    = in_eop ? FLUSH : PACK;
      end else begin
        // Not enough bytes for a word yet.
        r_next        = total[2:0];
        res_next      = merged[119:64];
        sop_pend_next = eff_sop;
        state_next    = PACK;
      end
    end
  end

  // Packing state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      r_reg        <= 3'd0;
      res_reg      <= 56'd0;
      len_reg      <= 16'd0;
      sop_pend_reg <= 1'b0;
      orphan_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      r_reg        <= r_next;
      res_reg      <= res_next;
      len_reg      <= len_next;
      sop_pend_reg <= sop_pend_next;
      orphan_reg   <= orphan_next;
    end
  end

  // Output register: loads a new word when free, otherwise holds until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_reg  <= 1'b0;
      out_data_reg <= 64'd0;
      out_sop_reg  <= 1'b0;
      out_eop_reg  <= 1'b0;
      out_byte_reg <= 3'd0;
      out_len_reg  <= 16'd0;
      out_err_reg  <= 1'b0;
    end else if (load) begin
      out_vld_reg  <= 1'b1;
      out_data_reg <= ld_data;
      out_sop_reg  <= ld_sop;
      out_eop_reg  <= ld_eop;
      out_byte_reg <= ld_byte;
      out_len_reg  <= ld_len;
      out_err_reg  <= ld_err;
    end else if (out_ready) begin
      out_vld_reg  <= 1'b0;
    end
  end

  // Statistics counters, updated in the cycle the eop word is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_reg <= '0;
      err_cnt_reg <= '0;
    end else begin
      if (pkt_inc) pkt_cnt_reg <= pkt_cnt_reg + CNT_ONE;
      if (err_inc) err_cnt_reg <= err_cnt_reg + CNT_ONE;
    end
  end

  assign out_vld  = out_vld_reg;
  assign out_data = out_data_reg;
  assign out_sop  = out_sop_reg;
  assign out_eop  = out_eop_reg;
  assign out_byte = out_byte_reg;
  assign out_len  = out_len_reg;
  assign out_err  = out_err_reg;
  assign pkt_cnt  = pkt_cnt_reg;
  assign err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_market_pkt_repack.sv
// Testbench for market_pkt_repack: directed cases plus randomized traffic,
// checked by a byte-level reference model feeding an expected-word queue.
`timescale 1ns/1ps
module tb_market_pkt_repack;

  localparam logic [15:0] MAXL = 16'd60;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic [63:0] in_data;
  logic        in_sop;
  logic [3:0]  in_offset;
  logic        in_eop;
  logic [2:0]  in_byte;
  logic        in_ready;
  logic        out_vld;
  logic [63:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic [2:0]  out_byte;
  logic [15:0] out_len;
  logic        out_err;
  logic        out_ready;
  logic [31:0] pkt_cnt;
  logic [31:0] err_cnt;

  always #5 clk = ~clk;

  market_pkt_repack #(.MAX_LEN(MAXL), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_data(in_data), .in_sop(in_sop), .in_offset(in_offset),
    .in_eop(in_eop), .in_byte(in_byte), .in_ready(in_ready),
    .out_vld(out_vld), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_byte(out_byte), .out_len(out_len), .out_err(out_err), .out_ready(out_ready),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  byt;
    logic [15:0] len;
    logic        err;
  } exp_t;

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic [3:0]  off;
    logic        eop;
    logic [2:0]  byt;
  } beat_t;

  exp_t  exp_q[$];
  beat_t pkt_beats[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    exp_pkt = 0;
  int    exp_err = 0;
  int    ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
  bit    gaps = 0;

  logic [63:0] last_data;
  logic [2:0]  last_byte;
  logic [15:0] last_len;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: collect payload bytes from the beats, then cut them
  // into 8-byte words.
  task automatic model_packet(input bit aborted);
    logic [7:0] pl[$];
    int   s, e, len, nw;
    exp_t w;
    foreach (pkt_beats[i]) begin
      s = pkt_beats[i].sop ? ((pkt_beats[i].off > 7) ? 7 : int'(pkt_beats[i].off)) : 0;
      e = pkt_beats[i].eop ? ((pkt_beats[i].byt == 0) ? 8 : int'(pkt_beats[i].byt)) : 8;
      for (int b = s; b < e; b++) pl.push_back(pkt_beats[i].d[63-8*b -: 8]);
    end
    len = pl.size();
    if (!aborted && len == 0) begin
      exp_err++;
      return;
    end
    nw = (len + 7) / 8;
    for (int k = 0; k < nw; k++) begin
      w.data = 64'd0;
      for (int b = 0; b < 8; b++)
        if (8*k + b < len) w.data[63-8*b -: 8] = pl[8*k+b];
      w.sop = (k == 0);
      w.eop = (k == nw - 1) && !(aborted && (len % 8 == 0));
      w.byt = w.eop ? 3'(len % 8) : 3'd0;
      w.len = w.eop ? 16'(len) : 16'd0;
      w.err = w.eop && (aborted || (len > int'(MAXL)));
      exp_q.push_back(w);
    end
    if (aborted && (len % 8 == 0)) begin
      w.data = 64'd0; w.sop = 1'b0; w.eop = 1'b1; w.byt = 3'd1;
      w.len = 16'(len); w.err = 1'b1;
      exp_q.push_back(w);
    end
    if (aborted || len > int'(MAXL)) exp_err++;
    else exp_pkt++;
  endtask

  // Drive one beat and hold it until accepted (bounded).
  task automatic send_beat(input beat_t b);
    int t = 0;
    bit rdy;
    in_vld = 1'b1; in_data = b.d; in_sop = b.sop; in_offset = b.off;
    in_eop = b.eop; in_byte = b.byt;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      t++;
      if (t > 2000) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout actual=no_ready required=ready");
        break;
      end
    end
    #1;
    in_vld = 1'b0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_packet();
    foreach (pkt_beats[i]) send_beat(pkt_beats[i]);
  endtask

  task automatic add_beat(input logic [63:0] d, input logic sop, input logic [3:0] off,
                          input logic eop, input logic [2:0] byt);
    beat_t b;
    b.d = d; b.sop = sop; b.off = off; b.eop = eop; b.byt = byt;
    pkt_beats.push_back(b);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || out_vld) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_drain_timeout actual=%0d_pending required=0", tag, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
    check({tag, "_err_cnt"}, err_cnt, exp_err);
  endtask

  // Downstream ready pattern.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every delivered word, stall stability and backpressure.
  logic        stall_prev = 1'b0;
  logic [85:0] held;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("hold_stable", {out_vld, out_data, out_sop, out_eop, out_byte, out_len, out_err},
              {1'b1, held});
      if (out_vld && !out_ready)
        check("stall_in_ready", in_ready, 1'b0);
      if (out_vld && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_word actual=%0h required=none", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word",
                {out_data, out_sop, out_eop, out_err,
                 (e.eop ? out_byte : 3'd0), (e.eop ? out_len : 16'd0)},
                {e.data, e.sop, e.eop, e.err, e.byt, e.len});
          if (out_eop) begin
            last_data = out_data; last_byte = out_byte; last_len = out_len;
          end
        end
      end
      stall_prev = out_vld && !out_ready;
      held = {out_data, out_sop, out_eop, out_byte, out_len, out_err};
    end
  end

  initial begin
    bit prev_aborted;
    in_vld = 0; in_data = 0; in_sop = 0; in_offset = 0; in_eop = 0; in_byte = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {out_vld, out_data, out_sop, out_eop, out_byte, out_len, out_err,
                            pkt_cnt, err_cnt}, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_in_ready", in_ready, 1'b1);

    // 1: single beat, offset 3, byte 7
    pkt_beats.delete();
    add_beat(64'h0011_2233_4455_6677, 1, 4'd3, 1, 3'd7);
    model_packet(0);
    send_packet();
    check("t1_latency", out_vld, 1'b1);
    drain("t1");
    check("t1_word", {last_data, last_byte, last_len}, {64'h3344_5566_0000_0000, 3'd4, 16'd4});

    // 2: three beats, offset 2, eop byte 5
    pkt_beats.delete();
    add_beat(64'h0001_0203_0405_0607, 1, 4'd2, 0, 3'd0);
    add_beat(64'h0809_0A0B_0C0D_0E0F, 0, 4'd0, 0, 3'd0);
    add_beat(64'h1011_1213_1415_1617, 0, 4'd0, 1, 3'd5);
    model_packet(0);
    send_packet();
    drain("t2");
    check("t2_last", {last_data, last_byte, last_len}, {64'h1213_1400_0000_0000, 3'd3, 16'd19});

    // 3: offset 0, byte 0, 16 bytes
    pkt_beats.delete();
    add_beat(64'hA0A1_A2A3_A4A5_A6A7, 1, 4'd0, 0, 3'd0);
    add_beat(64'hB0B1_B2B3_B4B5_B6B7, 0, 4'd0, 1, 3'd0);
    model_packet(0);
    send_packet();
    drain("t3");
    check("t3_last", {last_data, last_byte, last_len}, {64'hB0B1_B2B3_B4B5_B6B7, 3'd0, 16'd16});

    // 4: offset 1, 15 bytes, downstream stalls 5 cycles mid-stream
    pkt_beats.delete();
    add_beat(64'hC0C1_C2C3_C4C5_C6C7, 1, 4'd1, 0, 3'd0);
    add_beat(64'hD0D1_D2D3_D4D5_D6D7, 0, 4'd0, 1, 3'd0);
    model_packet(0);
    fork
      send_packet();
      begin
        int t = 0;
        while (!out_vld && t < 200) begin @(negedge clk); t++; end
        ready_mode = 2;
        repeat (5) @(posedge clk);
        ready_mode = 0;
      end
    join
    drain("t4");
    check("t4_last", {last_byte, last_len}, {3'd7, 16'd15});

    // 5: aborted packet followed by an intact one
    pkt_beats.delete();
    add_beat(64'h1111_1111_2222_2222, 1, 4'd4, 0, 3'd0);
    add_beat(64'h3333_3333_4444_4444, 0, 4'd0, 0, 3'd0);
    model_packet(1);
    send_packet();
    pkt_beats.delete();
    add_beat(64'h5555_6666_7777_8888, 1, 4'd0, 0, 3'd0);
    add_beat(64'h9999_AAAA_BBBB_CCCC, 0, 4'd0, 1, 3'd2);
    model_packet(0);
    send_packet();
    drain("t5");

    // 6: asynchronous reset mid-packet with a word waiting in the output
    ready_mode = 2;
    pkt_beats.delete();
    add_beat(64'hDEAD_BEEF_0123_4567, 1, 4'd0, 0, 3'd0);
    send_packet();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_reset", {out_vld, out_data, out_eop, pkt_cnt, err_cnt}, 128'd0);
    exp_q.delete();
    exp_pkt = 0;
    exp_err = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    pkt_beats.delete();
    add_beat(64'h0102_0304_0506_0708, 1, 4'd5, 0, 3'd0);
    add_beat(64'h1112_1314_1516_1718, 0, 4'd0, 1, 3'd4);
    model_packet(0);
    send_packet();
    drain("t6");
    check("t6_last", {last_data, last_byte, last_len}, {64'h0607_0811_1213_1400, 3'd7, 16'd7});

    // Randomized traffic: normal, oversize, zero-length, aborted, orphans
    ready_mode = 1;
    gaps = 1;
    prev_aborted = 0;
    for (int p = 0; p < 300; p++) begin
      int  kind, nb;
      bit  ab;
      kind = $urandom_range(0, 99);
      if (!prev_aborted && $urandom_range(0, 9) == 0) begin
        pkt_beats.delete();
        for (int o = 0; o < int'($urandom_range(1, 3)); o++)
          add_beat({$urandom, $urandom}, 0, 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        exp_err++;
        send_packet();
      end
      pkt_beats.delete();
      ab = 0;
      if (kind < 6) begin
        int s, e;
        s = $urandom_range(1, 9);
        e = $urandom_range(1, (s > 7) ? 7 : s);
        add_beat({$urandom, $urandom}, 1, 4'(s), 1, 3'(e));
      end else begin
        ab = (kind >= 80) && (p < 299);
        nb = $urandom_range(1, 10);
        for (int i = 0; i < nb; i++)
          add_beat({$urandom, $urandom}, (i == 0),
                   (i == 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15)),
                   (i == nb - 1) && !ab, 3'($urandom_range(0, 7)));
      end
      model_packet(ab);
      send_packet();
      prev_aborted = ab;
    end
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
